// File: rtl/ct_l2c_sram_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ct_l2c_sram_arb : round-robin arbiter for two requesters sharing one
//                   single-port L2 SRAM, with optional zero-fill after reset.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module ct_l2c_sram_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128,
  parameter int INIT_EN    = 1
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,

  input  logic                    r0_vld,
  input  logic                    r0_wr,
  input  logic [ADDR_WIDTH-1:0]   r0_addr,
  input  logic [DATA_WIDTH-1:0]   r0_wdata,
  input  logic [DATA_WIDTH/8-1:0] r0_be,
  output logic                    r0_rdy,

  input  logic                    r1_vld,
  input  logic                    r1_wr,
  input  logic [ADDR_WIDTH-1:0]   r1_addr,
  input  logic [DATA_WIDTH-1:0]   r1_wdata,
  input  logic [DATA_WIDTH/8-1:0] r1_be,
  output logic                    r1_rdy,

  output logic                    rsp0_vld,
  output logic                    rsp1_vld,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    init_done,

  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_ptr;
  logic                    r_p1_vld;
  logic                    r_p1_id;
  logic                    r_rsp0_vld;
  logic                    r_rsp1_vld;
  logic [DATA_WIDTH-1:0]   r_rsp_data;

  logic                    w_run;
  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_wr;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [BE_WIDTH-1:0]     w_be;
  logic [DATA_WIDTH-1:0]   w_wmask;
  logic                    w_rd_acc;
  logic                    w_wr_acc;

  // Pointer names the requester that wins when both are valid.
  assign w_run  = (r_state == ST_RUN) & ~cpurst;
  assign w_gnt0 = w_run & r0_vld & (~r1_vld | ~r_ptr);
  assign w_gnt1 = w_run & r1_vld & (~r0_vld |  r_ptr);

  assign r0_rdy = w_gnt0;
  assign r1_rdy = w_gnt1;

  assign w_wr    = w_gnt1 ? r1_wr    : r0_wr;
  assign w_addr  = w_gnt1 ? r1_addr  : r0_addr;
  assign w_wdata = w_gnt1 ? r1_wdata : r0_wdata;
  assign w_be    = w_gnt1 ? r1_be    : r0_be;

  // A write with no byte enabled is accepted but never reaches the macro.
  assign w_rd_acc = (w_gnt0 | w_gnt1) & ~w_wr;
  assign w_wr_acc = (w_gnt0 | w_gnt1) &  w_wr & (|w_be);

  generate
    for (genvar b = 0; b < BE_WIDTH; b++) begin : g_wen
      assign w_wmask[8*b +: 8] = {8{~w_be[b]}};
    end
  endgenerate

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (!cpurst && (r_state == ST_INIT)) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = r_cnt;
    end else if (w_rd_acc) begin
      sram_cen  = 1'b0;
      sram_a    = w_addr;
    end else if (w_wr_acc) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = w_wmask;
      sram_a    = w_addr;
      sram_d    = w_wdata;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state    <= RST_STATE;
      r_cnt      <= '0;
      r_ptr      <= 1'b0;
      r_p1_vld   <= 1'b0;
      r_p1_id    <= 1'b0;
      r_rsp0_vld <= 1'b0;
      r_rsp1_vld <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == '1) begin
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (w_gnt0 | w_gnt1) begin
            r_ptr <= w_gnt0;
          end
        end
      endcase

      // Macro data arrives one cycle after the access; register it one more.
      r_p1_vld   <= w_rd_acc;
      r_p1_id    <= w_gnt1;
      r_rsp0_vld <= r_p1_vld & ~r_p1_id;
      r_rsp1_vld <= r_p1_vld &  r_p1_id;
      if (r_p1_vld) begin
        r_rsp_data <= sram_q;
      end
    end
  end

  assign rsp0_vld  = r_rsp0_vld;
  assign rsp1_vld  = r_rsp1_vld;
  assign rsp_data  = r_rsp_data;
  assign init_done = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ct_l2c_sram_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ct_l2c_sram_arb : scoreboard bench with a behavioural SRAM macro.
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_ct_l2c_sram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         cpurst;
  logic         r0_vld, r0_wr, r1_vld, r1_wr;
  logic [11:0]  r0_addr, r1_addr;
  logic [127:0] r0_wdata, r1_wdata;
  logic [15:0]  r0_be, r1_be;
  logic         r0_rdy, r1_rdy, rsp0_vld, rsp1_vld, init_done;
  logic [127:0] rsp_data;
  logic [11:0]  sram_a;
  logic         sram_cen, sram_gwen;
  logic [127:0] sram_wen, sram_d;
  logic [127:0] sram_q = '0;

  ct_l2c_sram_arb #(.ADDR_WIDTH(12), .DATA_WIDTH(128), .INIT_EN(1)) dut (
    .forever_cpuclk(clk), .cpurst(cpurst),
    .r0_vld(r0_vld), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_be(r0_be), .r0_rdy(r0_rdy),
    .r1_vld(r1_vld), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_be(r1_be), .r1_rdy(r1_rdy),
    .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp_data(rsp_data), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  // Macro powers up with garbage so the zero-fill is observable.
  logic [127:0] mem [0:4095] = '{default: {4{32'hDEADBEEF}}};
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mem[sram_a];
    end
  end

  typedef struct {
    int           due;
    bit           id;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [127:0] ref_mem [0:4095];
  logic [127:0] last_rsp = '0;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  bit           tb_ptr = 1'b0;
  bit           g0, g1, s_wr;
  logic [11:0]  s_a;
  logic [127:0] s_d;
  logic [15:0]  s_be;

  // Reference arbiter + memory model; responses are checked against it.
  always @(negedge clk) begin
    cyc++;
    if (rsp0_vld || rsp1_vld) begin
      checks++;
      if (rsp0_vld && rsp1_vld) begin
        failures++;
        $display("FAIL rsp_onehot: rsp0_vld=%b rsp1_vld=%b required at most one", rsp0_vld, rsp1_vld);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: cyc=%0d rsp1_vld=%b data=%h required no response", cyc, rsp1_vld, rsp_data);
      end else begin
        e = sb.pop_front();
        last_rsp = e.data;
        if (e.id !== rsp1_vld || e.data !== rsp_data || e.due != cyc) begin
          failures++;
          $display("FAIL rsp: cyc=%0d id=%b data=%h required cyc=%0d id=%b data=%h",
                   cyc, rsp1_vld, rsp_data, e.due, e.id, e.data);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL rsp_missing: cyc=%0d no response required id=%b data=%h", cyc, sb[0].id, sb[0].data);
      void'(sb.pop_front());
    end

    if (cpurst) begin
      sb.delete();
      tb_ptr = 1'b0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    end else if (mon_en) begin
      g0 = r0_vld && (!r1_vld || !tb_ptr);
      g1 = r1_vld && (!r0_vld ||  tb_ptr);
      checks++;
      if (r0_rdy !== g0 || r1_rdy !== g1) begin
        failures++;
        $display("FAIL rdy: cyc=%0d r0_rdy=%b r1_rdy=%b required %b %b", cyc, r0_rdy, r1_rdy, g0, g1);
      end
      if (g0 || g1) begin
        s_wr = g1 ? r1_wr : r0_wr;
        s_a  = g1 ? r1_addr : r0_addr;
        s_d  = g1 ? r1_wdata : r0_wdata;
        s_be = g1 ? r1_be : r0_be;
        if (s_wr) begin
          for (int b = 0; b < 16; b++)
            if (s_be[b]) ref_mem[s_a][8*b +: 8] = s_d[8*b +: 8];
        end else begin
          sb.push_back('{due: cyc + 2, id: g1, data: ref_mem[s_a]});
        end
        tb_ptr = g0;
      end
    end
  end

  task automatic set_req(input int r, input bit wr, input logic [11:0] a,
                         input logic [127:0] d, input logic [15:0] be);
    if (r == 0) begin
      r0_vld = 1'b1; r0_wr = wr; r0_addr = a; r0_wdata = d; r0_be = be;
    end else begin
      r1_vld = 1'b1; r1_wr = wr; r1_addr = a; r1_wdata = d; r1_be = be;
    end
  endtask

  task automatic idle_reqs();
    r0_vld = 1'b0;
    r1_vld = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cpurst = 1'b1;
    set_req(0, 1'b1, 12'h001, '1, 16'hFFFF);
    set_req(1, 1'b0, 12'h002, '0, 16'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy: r0_rdy=%b r1_rdy=%b required 0 0", r0_rdy, r1_rdy);
    end
    checks++;
    if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== '1 || sram_a !== '0 || sram_d !== '0) begin
      failures++;
      $display("FAIL reset_sram: cen=%b gwen=%b wen=%h a=%h d=%h required idle", sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
    end
    checks++;
    if (rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0 || rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_rsp: vld=%b%b data=%h required 00 and 0", rsp0_vld, rsp1_vld, rsp_data);
    end
    checks++;
    if (init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_init_done: got %b required 0", init_done);
    end
  endtask

  task automatic test_init();
    bit bad = 1'b0;
    next_cycle();
    cpurst = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (!bad && (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 ||
                   sram_a !== i[11:0] || init_done !== 1'b0 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL init_sweep: step=%0d a=%h cen=%b gwen=%b wen=%h d=%h done=%b rdy=%b%b required a=%h zero write",
                 i, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, init_done, r0_rdy, r1_rdy, i[11:0]);
      end
      if (i == 4000) idle_reqs();
    end
    checks++;
    if (bad) failures++;
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || sram_cen !== 1'b1 || sram_a !== '0) begin
      failures++;
      $display("FAIL init_end: done=%b cen=%b a=%h required 1 1 000", init_done, sram_cen, sram_a);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_read_zero();
    next_cycle();
    set_req(0, 1'b0, 12'h7FF, '0, 16'h0);
    @(negedge clk);
    checks++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_wen !== '1 || sram_a !== 12'h7FF) begin
      failures++;
      $display("FAIL read_drive: cen=%b gwen=%b wen=%h a=%h required 0 1 all-ones 7ff", sram_cen, sram_gwen, sram_wen, sram_a);
    end
    next_cycle();
    idle_reqs();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp0_vld !== 1'b1 || rsp_data !== '0) begin
      failures++;
      $display("FAIL read_zero: rsp0_vld=%b data=%h required 1 0", rsp0_vld, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    next_cycle();
    set_req(0, 1'b1, 12'h010, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'hFFFF);
    next_cycle();
    idle_reqs();
    set_req(1, 1'b1, 12'h020, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123, 16'hFFFF);
    next_cycle();
    set_req(0, 1'b0, 12'h010, '0, 16'h0);
    set_req(1, 1'b0, 12'h020, '0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({r0_rdy, r1_rdy} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant: step=%0d rdy=%b%b required %s", k, r0_rdy, r1_rdy, (k % 2 == 0) ? "10" : "01");
      end
      next_cycle();
    end
    idle_reqs();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_byte_write();
    next_cycle();
    set_req(0, 1'b1, 12'h005, {16{8'hA5}}, 16'h0001);
    @(negedge clk);
    checks++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== {{120{1'b1}}, 8'h00} || sram_a !== 12'h005) begin
      failures++;
      $display("FAIL byte_write: cen=%b gwen=%b wen=%h a=%h required 0 0 low byte only 005", sram_cen, sram_gwen, sram_wen, sram_a);
    end
    next_cycle();
    set_req(0, 1'b0, 12'h005, '0, 16'h0);
    next_cycle();
    idle_reqs();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp0_vld !== 1'b1 || rsp_data !== 128'hA5) begin
      failures++;
      $display("FAIL byte_read: rsp0_vld=%b data=%h required 1 a5", rsp0_vld, rsp_data);
    end
  endtask

  task automatic test_be_zero();
    next_cycle();
    set_req(1, 1'b1, 12'h005, '1, 16'h0000);
    @(negedge clk);
    checks++;
    if (r1_rdy !== 1'b1 || sram_cen !== 1'b1) begin
      failures++;
      $display("FAIL be_zero: r1_rdy=%b cen=%b required 1 1", r1_rdy, sram_cen);
    end
    next_cycle();
    set_req(1, 1'b0, 12'h005, '0, 16'h0);
    next_cycle();
    idle_reqs();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp1_vld !== 1'b1 || rsp_data !== 128'hA5) begin
      failures++;
      $display("FAIL be_zero_read: rsp1_vld=%b data=%h required 1 a5", rsp1_vld, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] held;
    for (int k = 0; k < 48; k++) begin
      next_cycle();
      idle_reqs();
      if (k < 8) begin
        set_req(k % 2, 1'b0, 12'h010 + 12'(k % 2) * 12'h010, '0, 16'h0);
      end else begin
        for (int r = 0; r < 2; r++) begin
          if ($urandom_range(0, 3) != 0)
            set_req(r, ($urandom_range(0, 2) == 0), 12'h030 + 12'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom));
        end
      end
    end
    next_cycle();
    idle_reqs();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: %0d responses outstanding required 0", sb.size());
    end
    held = last_rsp;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_data !== held || rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0) begin
      failures++;
      $display("FAIL rsp_hold: data=%h vld=%b%b required %h 00", rsp_data, rsp0_vld, rsp1_vld, held);
    end
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    set_req(0, 1'b0, 12'h010, '0, 16'h0);
    @(negedge clk);
    checks++;
    if (r0_rdy !== 1'b1) begin
      failures++;
      $display("FAIL inflight_accept: r0_rdy=%b required 1", r0_rdy);
    end
    next_cycle();
    idle_reqs();
    mon_en = 1'b0;
    cpurst = 1'b1;
    next_cycle();
    cpurst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0 || sram_a !== i[11:0] || sram_cen !== 1'b0 || init_done !== 1'b0) begin
        failures++;
        $display("FAIL inflight_reset: step=%0d vld=%b%b a=%h cen=%b done=%b required 00 %h 0 0",
                 i, rsp0_vld, rsp1_vld, sram_a, sram_cen, init_done, i[11:0]);
      end
    end
  endtask

  initial begin
    r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
    r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0; r1_be = '0;
    test_reset();
    test_init();
    test_read_zero();
    test_round_robin();
    test_byte_write();
    test_be_zero();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ct_l2c_sram_arb.md
CT_L2C_SRAM_ARB -- requirements
Module: ct_l2c_sram_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, SRAM word address width (4096 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, SRAM data width; byte-enable width DATA_WIDTH/8.
REQ-003 SHALL have parameter INIT_EN, default 1, 1 = zero-fill the whole array after reset.
REQ-004 forever_cpuclk  in  1  sole clock; all state on its rising edge.
REQ-005 cpurst  in  1  reset, synchronous, active-high.
REQ-006 r0_vld / r1_vld  in  1  requester 0/1 request valid.
REQ-007 r0_wr / r1_wr  in  1  1 = write, 0 = read.
REQ-008 r0_addr / r1_addr  in  12  word address.
REQ-009 r0_wdata / r1_wdata  in  128  write data.
REQ-010 r0_be / r1_be  in  16  byte enables, active-high.
REQ-011 r0_rdy / r1_rdy  out  1  request accepted this cycle when vld & rdy.
REQ-012 rsp0_vld / rsp1_vld  out  1  read data valid for requester 0/1; one-cycle pulse, no backpressure.
REQ-013 rsp_data  out  128  read data, registered.
REQ-014 init_done  out  1  array initialised; requests allowed.
REQ-015 sram_a  out  12;  sram_cen  out  1 (active-low);  sram_gwen  out  1 (active-low write);  sram_wen  out  128 (active-low bit mask);  sram_d  out  128;  sram_q  in  128, valid the cycle after a read access.

Function
REQ-016 SHALL implement FSM states INIT and RUN; reset enters INIT if INIT_EN=1, else RUN.
REQ-017 INIT: 12-bit counter from 0, one write per cycle: cen=0, gwen=0, wen=all 0, d=0, a=counter.
REQ-018 INIT: counter==4095 write -> RUN next cycle; no wrap, no extra write.
REQ-019 init_done SHALL be 1 exactly while in RUN; r0_rdy=r1_rdy=0 in INIT.
REQ-020 RUN arbitration: round-robin, 1-bit priority pointer, reset to 0; single valid requester always granted; both valid -> pointer's requester granted.
REQ-021 Pointer SHALL move to the non-granted requester after every grant; unchanged on idle cycles.
REQ-022 rdyN SHALL equal grantN (combinational from vld and pointer); at most one rdy high per cycle.
REQ-023 Accepted access SHALL drive the SRAM in the same cycle: cen=0, a=addr; write: gwen=0, d=wdata, wen[8b+7:8b]=~be[b]; read: gwen=1, wen=all 1.
REQ-024 Write with be=0 SHALL be accepted (rdy=1) but leave cen=1 (no access).
REQ-025 No access cycle: cen=1, gwen=1, wen=all 1, a=0, d=0.
REQ-026 Read accepted cycle T: pending stage captures requester id at end of T; rsp_data <= sram_q at end of T+1; rspN_vld=1 during T+2 only.
REQ-027 Back-to-back reads every cycle, either requester, SHALL produce responses every cycle, in acceptance order, full throughput.
REQ-028 Writes SHALL produce no response; read after write to same address in consecutive cycles SHALL return new data.
REQ-029 rsp_data SHALL hold its last value when no rsp_vld.
REQ-030 vld dropped without handshake SHALL have no effect; requests not held across cycles internally.

Reset
REQ-031 On cpurst=1 at a clock edge: state=INIT (or RUN if INIT_EN=0), counter=0, pointer=0, pending/response pipeline cleared, rsp0_vld=rsp1_vld=0, rsp_data=0, init_done=0 (1 if INIT_EN=0).
REQ-032 Reset during INIT or with reads in flight SHALL drop them (no rsp_vld afterwards) and restart the zero-fill from address 0.
REQ-033 While cpurst=1, SRAM outputs SHALL be idle values (REQ-025) and rdy=0.

Verification
REQ-034 Reset release, INIT_EN=1 -> 4096 zero writes to addresses 0..4095 on consecutive cycles, init_done rises the cycle after address 4095; read addr 0x7FF -> rsp_data=0.
REQ-035 Both requesters hold vld (r0 read 0x010, r1 read 0x020) for 4 cycles -> grants r0,r1,r0,r1; rsp0,rsp1,rsp0,rsp1 at T+2..T+5.
REQ-036 r0 write 0x005 data 0xA5 repeated, be=0x0001, then read 0x005 next cycle -> sram_wen low on bits 7:0 only; rsp_data=0x...00A5 (upper bytes 0).
REQ-037 r1 write be=0 -> r1_rdy=1, sram_cen stays 1; subsequent read returns prior contents.
REQ-038 Assert cpurst one cycle after a read is accepted -> no rsp_vld observed; INIT restarts at address 0.
